// File: rtl/mem_wb_nway_pkg.sv
// mem_wb_nway_pkg: shared MEM/WB pipeline types, DMW bit positions and helpers (DIFFTEST_EN adds difftest lane fields)
package mem_wb_nway_pkg;
  localparam int DW = 32;
  localparam int PLV0 = 0;
  localparam int PLV3 = 3;
  localparam int VSEG = 29;
  typedef struct packed {
    logic valid;
    logic [DW-1:0] pc;
    logic [31:0] instr;
    logic [4:0] waddr;
    logic we;
    logic [DW-1:0] wdata;
    logic load_op;
    logic store_op;
    logic excp;
    logic [9:0] excp_num;
    logic is_last_in_block;
  } mem_lane_t;
  typedef struct packed {
    logic found;
    logic v;
    logic d;
    logic [1:0] plv;
  } tlb_lane_t;
  typedef struct packed {
    logic [1:0] plv;
    logic da;
    logic pg;
    logic [31:0] dmw0;
    logic [31:0] dmw1;
  } csr_trans_t;
  typedef struct packed {
    logic valid;
    logic [DW-1:0] pc;
    logic [31:0] instr;
    logic [4:0] waddr;
    logic we;
    logic [DW-1:0] wdata;
    logic excp;
    logic [15:0] excp_num;
`ifdef DIFFTEST_EN
    logic inst_ld_en;
    logic inst_st_en;
    logic [DW-1:0] ld_paddr;
    logic [DW-1:0] st_paddr;
    logic [DW-1:0] st_data;
`endif
  } wb_lane_t;
  function automatic logic dmw_hit(input logic en0, input logic en3, input logic [2:0] vseg,
                                   input logic [1:0] plv, input logic [2:0] seg);
    return ((en0 && plv == 2'd0) || (en3 && plv == 2'd3)) && seg == vseg;
  endfunction
endpackage

// File: rtl/mem_wb_nway_excp_check.sv
// mem_excp_check: per-lane DMW/TLB translation exception classification
import mem_wb_nway_pkg::*;
module mem_excp_check (
  input  csr_trans_t  csr,
  input  tlb_lane_t   tlb,
  input  logic        ld,
  input  logic        st,
  input  logic [2:0]  va_seg,
  input  logic        in_excp,
  input  logic [9:0]  in_num,
  output logic        excp,
  output logic [15:0] excp_num
);
  logic dmw0_en, dmw1_en, trans_en, tlbr, pil, pis, ppi, pme, adem, unused;
  assign unused = ^{csr.dmw0, csr.dmw1};
  assign dmw0_en = dmw_hit(csr.dmw0[PLV0], csr.dmw0[PLV3], csr.dmw0[VSEG+:3], csr.plv, va_seg);
  assign dmw1_en = dmw_hit(csr.dmw1[PLV0], csr.dmw1[PLV3], csr.dmw1[VSEG+:3], csr.plv, va_seg);
  assign trans_en = !csr.da && csr.pg && !dmw0_en && !dmw1_en;
  assign tlbr = trans_en && (ld || st) && !tlb.found;
  assign pil = trans_en && ld && !tlb.v;
  assign pis = trans_en && st && !tlb.v;
  assign ppi = trans_en && (ld || st) && tlb.v && csr.plv > tlb.plv;
  assign pme = trans_en && st && tlb.v && csr.plv <= tlb.plv && !tlb.d;
  assign adem = 1'b0;
  assign excp_num = {pil, pis, ppi, pme, tlbr, adem, in_num};
  assign excp = pil || pis || ppi || pme || tlbr || adem || in_excp;
endmodule

// File: rtl/mem_wb_nway.sv
// mem_wb_nway: N-lane MEM->WB register with skid buffer and precise TLB exceptions (DIFFTEST_EN adds difftest fields)
import mem_wb_nway_pkg::*;
module mem_wb_nway #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DATA_WIDTH = DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  mem_lane_t [ISSUE_WIDTH-1:0] in_lane,
  input  tlb_lane_t [ISSUE_WIDTH-1:0] tlb_lane,
  input  csr_trans_t                  csr_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output wb_lane_t [ISSUE_WIDTH-1:0]  out_lane,
  output logic                        out_is_last_in_block
);
  if (DATA_WIDTH != DW) begin : g_bad_width
    $error("DATA_WIDTH must match the package lane width");
  end
  wb_lane_t [ISSUE_WIDTH-1:0] cap_lane, main_lane, skid_lane;
  logic [ISSUE_WIDTH-1:0] lane_excp;
  logic [15:0] lane_num [ISSUE_WIDTH];
  logic kill, cap_any, cap_last, take, main_v, main_last, skid_v, skid_last;
  genvar i;
  for (i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    mem_excp_check u_chk (
      .csr(csr_in), .tlb(tlb_lane[i]), .ld(in_lane[i].load_op), .st(in_lane[i].store_op),
      .va_seg(in_lane[i].wdata[31:29]), .in_excp(in_lane[i].excp), .in_num(in_lane[i].excp_num),
      .excp(lane_excp[i]), .excp_num(lane_num[i])
    );
  end
  // capture view: lanes after the first excepting valid lane are squashed
  always_comb begin
    kill = 1'b0;
    cap_any = 1'b0;
    cap_last = 1'b0;
    cap_lane = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      cap_lane[k].valid = in_lane[k].valid && !kill;
      cap_lane[k].pc = in_lane[k].pc;
      cap_lane[k].instr = in_lane[k].instr;
      cap_lane[k].waddr = in_lane[k].waddr;
      cap_lane[k].we = in_lane[k].we && !kill;
      cap_lane[k].wdata = in_lane[k].wdata;
      cap_lane[k].excp = lane_excp[k];
      cap_lane[k].excp_num = lane_num[k];
`ifdef DIFFTEST_EN
      cap_lane[k].inst_ld_en = in_lane[k].load_op;
      cap_lane[k].inst_st_en = in_lane[k].store_op;
      cap_lane[k].ld_paddr = in_lane[k].load_op ? in_lane[k].wdata : '0;
      cap_lane[k].st_paddr = in_lane[k].store_op ? in_lane[k].wdata : '0;
      cap_lane[k].st_data = in_lane[k].store_op ? in_lane[k].wdata : '0;
`endif
      cap_any = cap_any || cap_lane[k].valid;
      cap_last = cap_last || (cap_lane[k].valid && in_lane[k].is_last_in_block);
      kill = kill || (in_lane[k].valid && lane_excp[k]);
    end
  end
  assign in_ready = !skid_v;
  assign take = in_valid && !skid_v && cap_any;
  // main/skid registers: refill main on drain (skid first), otherwise park the new bundle in skid
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_lane <= '0;
      skid_lane <= '0;
      main_last <= 1'b0;
      skid_last <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      main_v <= skid_v || take;
      main_lane <= skid_v ? skid_lane : cap_lane;
      main_last <= skid_v ? skid_last : cap_last;
      skid_v <= 1'b0;
    end else if (take) begin
      skid_v <= 1'b1;
      skid_lane <= cap_lane;
      skid_last <= cap_last;
    end
  end
  assign out_valid = main_v;
  assign out_lane = main_lane;
  assign out_is_last_in_block = main_v && main_last;
endmodule

// File: tb/tb_mem_wb_nway.sv
// tb_mem_wb_nway: directed self-checking bench for mem_wb_nway
import mem_wb_nway_pkg::*;
module tb_mem_wb_nway;
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_last;
  mem_lane_t [1:0] in_lane;
  tlb_lane_t [1:0] tlb_lane;
  csr_trans_t csr_in;
  wb_lane_t [1:0] out_lane;
  int n_chk = 0;
  int n_err = 0;
  mem_wb_nway #(.ISSUE_WIDTH(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane(in_lane), .tlb_lane(tlb_lane), .csr_in(csr_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane(out_lane), .out_is_last_in_block(out_last)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic mem_lane_t mk(input logic v, input logic ld, input logic st,
                                   input logic [31:0] pc, input logic [31:0] wd, input logic last);
    mk = '0;
    mk.valid = v;
    mk.pc = pc;
    mk.instr = 32'h0000_0013 ^ pc;
    mk.waddr = 5'd3;
    mk.we = 1'b1;
    mk.wdata = wd;
    mk.load_op = ld;
    mk.store_op = st;
    mk.is_last_in_block = last;
  endfunction
  task automatic tlb_vec(input string tag, input logic ld, input logic st, input logic found,
                         input logic v, input logic d, input logic [1:0] tplv,
                         input logic [1:0] cplv, input logic [15:0] exp_num);
    csr_in = '{plv: cplv, da: 1'b0, pg: 1'b1, dmw0: 32'h0, dmw1: 32'h0};
    tlb_lane[0] = '{found: found, v: v, d: d, plv: tplv};
    in_lane[0] = mk(1, ld, st, 32'h200, 32'h1000_0040, 0);
    in_lane[1] = mk(1, 0, 0, 32'h204, 32'h7, 1);
    @(negedge clk);
    check({tag, "_num"}, out_lane[0].excp_num, exp_num);
    check({tag, "_excp"}, out_lane[0].excp, exp_num != 16'h0);
    check({tag, "_l1v"}, out_lane[1].valid, exp_num == 16'h0);
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_lane = '0;
    tlb_lane = '0;
    csr_in = '{plv: 2'd0, da: 1'b1, pg: 1'b0, dmw0: 32'h0, dmw1: 32'h0};
    repeat (2) @(negedge clk);
    check("rst_ov", out_valid, 0);
    check("rst_ir", in_ready, 1);
    check("rst_last", out_last, 0);
    check("rst_lane", |out_lane, 0);
    rst = 0;
    csr_in = '{plv: 2'd0, da: 1'b0, pg: 1'b1, dmw0: 32'h0, dmw1: 32'h0};
    tlb_lane[0] = '{found: 1'b0, v: 1'b1, d: 1'b1, plv: 2'd3};
    tlb_lane[1] = '{found: 1'b1, v: 1'b1, d: 1'b1, plv: 2'd3};
    in_lane[0] = mk(1, 1, 0, 32'h1000, 32'h1234_0000, 0);
    in_lane[1] = mk(1, 0, 0, 32'h1004, 32'h5, 1);
    in_valid = 1;
    @(negedge clk);
    check("tlbr_ov", out_valid, 1);
    check("tlbr_excp", out_lane[0].excp, 1);
    check("tlbr_num", out_lane[0].excp_num, 16'h0800);
    check("tlbr_l1v", out_lane[1].valid, 0);
    check("tlbr_l1we", out_lane[1].we, 0);
    check("tlbr_last", out_last, 0);
    csr_in.dmw0 = 32'hA000_0001;
    in_lane[0].wdata = 32'hA000_0000;
    @(negedge clk);
    check("dmw_excp", out_lane[0].excp, 0);
    check("dmw_l1v", out_lane[1].valid, 1);
    check("dmw_last", out_last, 1);
    in_lane[0].wdata = 32'h8000_0000;
    @(negedge clk);
    check("dmw_seg_num", out_lane[0].excp_num, 16'h0800);
    in_lane[0].wdata = 32'hA000_0000;
    csr_in.plv = 2'd3;
    @(negedge clk);
    check("dmw_plv_num", out_lane[0].excp_num, 16'h0800);
    tlb_vec("pme", 0, 1, 1, 1, 0, 2'd3, 2'd3, 16'h1000);
    tlb_vec("dirty", 0, 1, 1, 1, 1, 2'd3, 2'd3, 16'h0000);
    tlb_vec("ppi", 1, 0, 1, 1, 1, 2'd0, 2'd3, 16'h2000);
    tlb_vec("pil", 1, 0, 1, 0, 1, 2'd3, 2'd0, 16'h8000);
    tlb_vec("pis", 0, 1, 1, 0, 1, 2'd3, 2'd0, 16'h4000);
    tlb_vec("tlbr_pil", 1, 0, 0, 0, 0, 2'd3, 2'd0, 16'h8800);
    csr_in = '{plv: 2'd0, da: 1'b1, pg: 1'b0, dmw0: 32'h0, dmw1: 32'h0};
    in_lane[0].excp = 1;
    in_lane[0].excp_num = 10'h005;
    @(negedge clk);
    check("pass_num", out_lane[0].excp_num, 16'h0005);
    check("pass_excp", out_lane[0].excp, 1);
    in_lane = '0;
    @(negedge clk);
    check("empty_ov", out_valid, 0);
    in_lane[0] = mk(1, 0, 0, 32'h100, 32'h1, 0);
    in_lane[1] = mk(1, 0, 0, 32'h104, 32'h2, 0);
    out_ready = 0;
    @(negedge clk);
    check("stall_a", out_lane[0].pc, 32'h100);
    check("stall_ir0", in_ready, 1);
    in_lane[0].pc = 32'h110;
    @(negedge clk);
    check("stall_hold1", out_lane[0].pc, 32'h100);
    check("stall_ir1", in_ready, 0);
    in_lane[0].pc = 32'h120;
    @(negedge clk);
    check("stall_hold2", out_lane[0].pc, 32'h100);
    check("stall_ir2", in_ready, 0);
    out_ready = 1;
    @(negedge clk);
    check("drain_b", out_lane[0].pc, 32'h110);
    check("drain_bv", out_valid, 1);
    check("drain_ir", in_ready, 1);
    @(negedge clk);
    check("drain_c", out_lane[0].pc, 32'h120);
    in_valid = 0;
    @(negedge clk);
    check("drain_end", out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    in_lane[0].pc = 32'h300;
    @(negedge clk);
    in_lane[0].pc = 32'h310;
    @(negedge clk);
    check("fl_full", in_ready, 0);
    flush = 1;
    in_lane[0].pc = 32'h320;
    @(negedge clk);
    check("fl_ov", out_valid, 0);
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("fl_ov2", out_valid, 0);
    check("fl_ir", in_ready, 1);
    out_ready = 0;
    in_valid = 1;
    in_lane[0].pc = 32'h400;
    @(negedge clk);
    check("rst2_pre", out_valid, 1);
    rst = 1;
    @(negedge clk);
    check("rst2_ov", out_valid, 0);
    check("rst2_ir", in_ready, 1);
    check("rst2_lane", |out_lane, 0);
    check("rst2_last", out_last, 0);
    rst = 0;
    in_valid = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
